// File: rtl/dw_ahb_dmac_arb_grant_mi_if.sv
// Request/grant bundle between one master interface's request block, the
// channel grant logic and the AHB arbiter.
//   req_mi, req_mbiu, req_mbiu_exclude_current : masked channel requests
//   ch_lock                                    : per-channel CFG lock bit
//   hgrant, hready, xfer_done                  : bus status / burst completion
//   grant_mi, mask_lck_ch, hbusreq, hlock      : grant-side results
// master = grant block, slave = surrounding request/arbiter logic.
interface dw_ahb_dmac_arb_grant_mi_if #(
  parameter int unsigned NUM_CH = 8
);
  logic [NUM_CH-1:0] req_mi;
  logic              req_mbiu;
  logic              req_mbiu_exclude_current;
  logic [NUM_CH-1:0] ch_lock;
  logic              hgrant;
  logic              hready;
  logic              xfer_done;
  logic [NUM_CH-1:0] grant_mi;
  logic [NUM_CH-1:0] mask_lck_ch;
  logic              hbusreq;
  logic              hlock;

  modport master (
    input  req_mi, req_mbiu, req_mbiu_exclude_current, ch_lock,
    input  hgrant, hready, xfer_done,
    output grant_mi, mask_lck_ch, hbusreq, hlock
  );

  modport slave (
    output req_mi, req_mbiu, req_mbiu_exclude_current, ch_lock,
    output hgrant, hready, xfer_done,
    input  grant_mi, mask_lck_ch, hbusreq, hlock
  );
endinterface

// File: rtl/dw_ahb_dmac_arb_grant_mi.sv
// Grant side of one master interface's request path: runs the AHB
// hbusreq/hgrant handshake, picks a channel round-robin, drives grant_mi and
// keeps channel-lock state (mask_lck_ch, hlock).
// Ports:
//   hclk, hresetn : clock, asynchronous active-low reset
//   bus           : request/grant bundle (master modport); all outputs registered
module dw_ahb_dmac_arb_grant_mi #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned CH_W   = 3
) (
  input  logic                              hclk,
  input  logic                              hresetn,
  dw_ahb_dmac_arb_grant_mi_if.master        bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSREQ = 2'd1;
  localparam logic [1:0] OWN    = 2'd2;

  logic [1:0]        state_q,   state_nxt;
  logic [NUM_CH-1:0] grant_q,   grant_nxt;
  logic [NUM_CH-1:0] mask_q,    mask_nxt;
  logic              busreq_q,  busreq_nxt;
  logic              hlock_q,   hlock_nxt;
  logic [CH_W-1:0]   last_q,    last_nxt;
  logic [CH_W-1:0]   cur_q,     cur_nxt;

  logic [NUM_CH-1:0] cand;
  logic [CH_W-1:0]   idx;
  logic [CH_W-1:0]   win_idx;
  logic              win_found;
  logic              locked;
  logic              takeaway;
  logic              remain;

  // Round-robin search starting just above the last winner, wrapping.
  always_comb begin
    cand      = bus.req_mi & ~mask_q;
    idx       = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      idx = CH_W'((32'(last_q) + i) % NUM_CH);
      if (!win_found && cand[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  // State register and registered outputs.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      mask_q   <= '0;
      busreq_q <= 1'b0;
      hlock_q  <= 1'b0;
      last_q   <= CH_W'(NUM_CH - 1);
      cur_q    <= '0;
    end else begin
      state_q  <= state_nxt;
      grant_q  <= grant_nxt;
      mask_q   <= mask_nxt;
      busreq_q <= busreq_nxt;
      hlock_q  <= hlock_nxt;
      last_q   <= last_nxt;
      cur_q    <= cur_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt  = state_q;
    grant_nxt  = grant_q;
    mask_nxt   = mask_q;
    busreq_nxt = busreq_q;
    hlock_nxt  = hlock_q;
    last_nxt   = last_q;
    cur_nxt    = cur_q;
    locked     = bus.ch_lock[cur_q];
    takeaway   = bus.hready & ~bus.hgrant;
    remain     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_mbiu) begin
          busreq_nxt = 1'b1;
          state_nxt  = BUSREQ;
        end
      end

      BUSREQ: begin
        if (!bus.req_mbiu) begin
          // Withdrawal wins over a simultaneous grant; drop any stale lock.
          busreq_nxt = 1'b0;
          mask_nxt   = '0;
          hlock_nxt  = 1'b0;
          state_nxt  = IDLE;
        end else if (bus.hgrant && bus.hready && win_found) begin
          grant_nxt = NUM_CH'(1) << win_idx;
          hlock_nxt = bus.ch_lock[win_idx];
          cur_nxt   = win_idx;
          state_nxt = OWN;
        end
      end

      OWN: begin
        if (bus.xfer_done) begin
          last_nxt = cur_q;
          if (locked) begin
            mask_nxt  = ~grant_q;
            hlock_nxt = 1'b1;
          end else begin
            mask_nxt  = '0;
            hlock_nxt = 1'b0;
          end
          // A locked channel keeps the grant unless the bus is also taken away.
          if (takeaway || !locked) begin
            grant_nxt = '0;
            remain    = locked ? bus.req_mbiu : bus.req_mbiu_exclude_current;
            if (remain) begin
              state_nxt = BUSREQ;
            end else begin
              busreq_nxt = 1'b0;
              mask_nxt   = '0;
              hlock_nxt  = 1'b0;
              state_nxt  = IDLE;
            end
          end
        end else if (takeaway) begin
          grant_nxt = '0;
          state_nxt = BUSREQ;
        end
      end

      default: begin
        grant_nxt  = '0;
        mask_nxt   = '0;
        busreq_nxt = 1'b0;
        hlock_nxt  = 1'b0;
        state_nxt  = IDLE;
      end
    endcase
  end

  assign bus.grant_mi    = grant_q;
  assign bus.mask_lck_ch = mask_q;
  assign bus.hbusreq     = busreq_q;
  assign bus.hlock       = hlock_q;

endmodule

// File: tb/tb_dw_ahb_dmac_arb_grant_mi.sv
// Directed bench for dw_ahb_dmac_arb_grant_mi with NUM_CH=4.
module tb_dw_ahb_dmac_arb_grant_mi;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 2;

  logic hclk;
  logic hresetn;
  int   n_chk;
  int   n_fail;

  dw_ahb_dmac_arb_grant_mi_if #(.NUM_CH(NUM_CH)) bus ();

  dw_ahb_dmac_arb_grant_mi #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    hresetn = 1'b0;
    bus.req_mi                   = '0;
    bus.req_mbiu                 = 1'b0;
    bus.req_mbiu_exclude_current = 1'b0;
    bus.ch_lock                  = '0;
    bus.hgrant                   = 1'b0;
    bus.hready                   = 1'b0;
    bus.xfer_done                = 1'b0;

    // Reset state
    step(); step();
    chk("rst_grant",  32'(bus.grant_mi),    32'h0);
    chk("rst_mask",   32'(bus.mask_lck_ch), 32'h0);
    chk("rst_busreq", 32'(bus.hbusreq),     32'h0);
    chk("rst_hlock",  32'(bus.hlock),       32'h0);
    hresetn = 1'b1;
    step();
    chk("idle_busreq", 32'(bus.hbusreq), 32'h0);

    // Basic grant: last=3 after reset, so channel 1 wins from 1010
    bus.req_mi   = 4'b1010;
    bus.req_mbiu = 1'b1;
    bus.hgrant   = 1'b1;
    bus.hready   = 1'b1;
    step();
    chk("basic_busreq_t1", 32'(bus.hbusreq),  32'h1);
    chk("basic_grant_t1",  32'(bus.grant_mi), 32'h0);
    step();
    chk("basic_grant_t2", 32'(bus.grant_mi), 32'h2);
    chk("basic_hlock",    32'(bus.hlock),    32'h0);
    bus.xfer_done = 1'b1;
    bus.req_mbiu_exclude_current = 1'b1;
    step();
    bus.xfer_done = 1'b0;
    chk("basic_release", 32'(bus.grant_mi), 32'h0);
    chk("basic_busreq_kept", 32'(bus.hbusreq), 32'h1);
    step();
    chk("basic_regrant", 32'(bus.grant_mi), 32'h8);

    // Round-robin wrap: last becomes 3, 1001 -> channel 0, then channel 3
    bus.req_mi    = 4'b1001;
    bus.xfer_done = 1'b1;
    step();
    bus.xfer_done = 1'b0;
    chk("rr_release", 32'(bus.grant_mi), 32'h0);
    step();
    chk("rr_wrap", 32'(bus.grant_mi), 32'h1);
    bus.xfer_done = 1'b1;
    step();
    bus.xfer_done = 1'b0;
    step();
    chk("rr_next", 32'(bus.grant_mi), 32'h8);

    // Lock: channel 2 locked holds the grant while 0011 waits
    bus.req_mi    = 4'b0100;
    bus.ch_lock   = 4'b0100;
    bus.xfer_done = 1'b1;
    step();
    bus.xfer_done = 1'b0;
    step();
    chk("lock_grant", 32'(bus.grant_mi), 32'h4);
    chk("lock_hlock_grant", 32'(bus.hlock), 32'h1);
    bus.req_mi    = 4'b0111;
    bus.xfer_done = 1'b1;
    step();
    bus.xfer_done = 1'b0;
    chk("lock_mask",  32'(bus.mask_lck_ch), 32'hb);
    chk("lock_held",  32'(bus.grant_mi),    32'h4);
    chk("lock_hlock", 32'(bus.hlock),       32'h1);
    step();
    chk("lock_still_held", 32'(bus.grant_mi), 32'h4);
    bus.ch_lock   = 4'b0000;
    bus.xfer_done = 1'b1;
    step();
    bus.xfer_done = 1'b0;
    chk("unlock_grant", 32'(bus.grant_mi),    32'h0);
    chk("unlock_mask",  32'(bus.mask_lck_ch), 32'h0);
    chk("unlock_hlock", 32'(bus.hlock),       32'h0);
    step();
    chk("unlock_regrant", 32'(bus.grant_mi), 32'h1);

    // Bus takeaway: grant drops, hbusreq stays, same channel re-granted
    bus.hgrant = 1'b0;
    step();
    chk("take_grant",  32'(bus.grant_mi), 32'h0);
    chk("take_busreq", 32'(bus.hbusreq),  32'h1);
    step();
    chk("take_wait", 32'(bus.grant_mi), 32'h0);
    bus.hgrant = 1'b1;
    step();
    chk("take_regrant", 32'(bus.grant_mi), 32'h1);

    // Withdraw in BUSREQ beats a simultaneous hgrant
    bus.hgrant = 1'b0;
    step();
    bus.req_mbiu = 1'b0;
    bus.hgrant   = 1'b1;
    step();
    chk("wd_busreq", 32'(bus.hbusreq),  32'h0);
    chk("wd_grant",  32'(bus.grant_mi), 32'h0);
    step();
    chk("wd_idle_grant",  32'(bus.grant_mi), 32'h0);
    chk("wd_idle_busreq", 32'(bus.hbusreq),  32'h0);

    // Reset during a locked OWN clears everything at once
    bus.req_mbiu = 1'b1;
    step();
    chk("pre_rst_busreq", 32'(bus.hbusreq), 32'h1);
    step();
    chk("pre_rst_grant", 32'(bus.grant_mi), 32'h1);
    bus.ch_lock   = 4'b0001;
    bus.req_mi    = 4'b0011;
    bus.xfer_done = 1'b1;
    step();
    bus.xfer_done = 1'b0;
    chk("pre_rst_mask",  32'(bus.mask_lck_ch), 32'he);
    chk("pre_rst_hlock", 32'(bus.hlock),       32'h1);
    #1 hresetn = 1'b0;
    #1;
    chk("mid_rst_grant",  32'(bus.grant_mi),    32'h0);
    chk("mid_rst_mask",   32'(bus.mask_lck_ch), 32'h0);
    chk("mid_rst_busreq", 32'(bus.hbusreq),     32'h0);
    chk("mid_rst_hlock",  32'(bus.hlock),       32'h0);
    bus.req_mbiu = 1'b0;
    bus.ch_lock  = 4'b0000;
    @(negedge hclk);
    hresetn = 1'b1;
    step();
    chk("post_rst_idle", 32'(bus.hbusreq), 32'h0);
    bus.req_mi   = 4'b1010;
    bus.req_mbiu = 1'b1;
    step();
    chk("post_rst_busreq", 32'(bus.hbusreq), 32'h1);
    step();
    chk("post_rst_last", 32'(bus.grant_mi), 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
